// File: rtl/audio_sample_fifo.sv
// Purpose : stereo {left,right} sample FIFO feeding the SSM2603 serializer; bus side pushes, codec side pops per LRCK frame.
// Latency : a pushed pair is poppable the next cycle; audio_output/channel_sel update one clk after a sample_req pulse.
// Backpres: wr_full flags a full FIFO; a push while full (without a coincident pop) is dropped and sets sticky overflow.
//
// Ports:
//   clk, reset_n          codec clock, asynchronous active-low reset
//   enable                1 = service sample_req, 0 = drive silence and never pop
//   flush                 empty the FIFO (rd_ptr <= wr_ptr) and clear overflow
//   wr_en, wr_data        push a {left[31:16], right[15:0]} pair
//   wr_full, level        occupancy status; low_water = enable && level <= LOW_WATER
//   overflow              sticky push-while-full flag
//   clear_status          clears overflow and underrun_count
//   underrun_count        saturating count of left requests that found the FIFO empty
//   sample_req            [1] left/new frame (pops), [0] right (replays held right half)
//   audio_output          sample presented to the codec
//   channel_sel           2'b10 left, 2'b01 right, 2'b00 silence
module audio_sample_fifo #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int LOW_WATER = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              wr_full,
    output logic [ADDR_W:0]   level,
    output logic              low_water,
    output logic              overflow,
    input  logic              clear_status,
    output logic [15:0]       underrun_count,
    input  logic [1:0]        sample_req,
    output logic [15:0]       audio_output,
    output logic [1:0]        channel_sel
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     LW_U    = LOW_WATER;

    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       underrun_q, underrun_d;
    logic [15:0]       audio_q, audio_d;
    logic [15:0]       hold_q, hold_d;
    logic [1:0]        chan_q, chan_d;

    logic              full, empty;
    logic              pop_req, pop_hit, push_ok, ovf_evt, und_evt;
    logic [31:0]       rd_pair;

    always_comb begin
        full    = (level_q == DEPTH_L);
        empty   = (level_q == '0);
        rd_pair = mem_q[rd_ptr_q];

        // sample_req == 2'b11 falls into the left branch because bit 1 is tested first.
        pop_req = enable && sample_req[1];
        pop_hit = pop_req && !empty;
        und_evt = pop_req && empty;

        // A pop in the same cycle frees the slot, so a push at full is still accepted.
        push_ok = wr_en && (!full || pop_hit) && !flush;
        ovf_evt = wr_en && full && !pop_hit && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop_hit) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({push_ok, pop_hit})
                2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
                default: level_d = level_q;
            endcase
        end

        // A set event wins over a same-cycle clear.
        overflow_d = overflow_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clear_status || flush) begin
            overflow_d = 1'b0;
        end

        underrun_d = underrun_q;
        if (clear_status) begin
            underrun_d = und_evt ? 16'd1 : 16'd0;
        end else if (und_evt && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end

        // The output path is independent of flush: a coincident left request still
        // presents the pair at the head before the FIFO is emptied.
        audio_d = audio_q;
        hold_d  = hold_q;
        chan_d  = chan_q;
        if (!enable) begin
            audio_d = 16'd0;
            chan_d  = 2'b00;
        end else if (sample_req[1]) begin
            chan_d = 2'b10;
            if (!empty) begin
                audio_d = rd_pair[31:16];
                hold_d  = rd_pair[15:0];
            end else begin
                audio_d = 16'd0;
                hold_d  = 16'd0;
            end
        end else if (sample_req[0]) begin
            audio_d = hold_q;
            chan_d  = 2'b01;
        end
    end

    // Sample storage carries no reset; occupancy is governed by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 16'd0;
            audio_q    <= 16'd0;
            hold_q     <= 16'd0;
            chan_q     <= 2'b00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            audio_q    <= audio_d;
            hold_q     <= hold_d;
            chan_q     <= chan_d;
        end
    end

    assign wr_full        = full;
    assign level          = level_q;
    assign low_water      = enable && ({{(31 - ADDR_W){1'b0}}, level_q} <= LW_U);
    assign overflow       = overflow_q;
    assign underrun_count = underrun_q;
    assign audio_output   = audio_q;
    assign channel_sel    = chan_q;

endmodule
